// File: rtl/calc_pkg.sv
// Definitions shared by the keypad entry block and the calculator core:
// key codes, operator encoding and BCD digit geometry.
package calc_pkg;

   localparam int BCD_W      = 4;
   localparam int NUM_DIGITS = 4;

   localparam logic [3:0] KEY_ADD  = 4'd10;
   localparam logic [3:0] KEY_SUB  = 4'd11;
   localparam logic [3:0] KEY_MUL  = 4'd12;
   localparam logic [3:0] KEY_EQ   = 4'd13;
   localparam logic [3:0] KEY_CLR  = 4'd14;
   localparam logic [3:0] KEY_BKSP = 4'd15;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_EQ  = 3'd3,
      OP_CLR = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_HELD
   } deb_state_e;

   function automatic logic is_digit(input logic [3:0] key);
      return key < 4'd10;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Turns the scanner's once-per-scan press pulses into one key event per press.
// Optional auto-repeat of digit/BKSP keys is enabled by KEY_ENTRY_REPEAT_EN.
module key_debounce
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SCAN_WINDOW     = 8,
   parameter int REPEAT_CYCLES   = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_value,
   input  logic       key_intro,
   output logic       key_event,
   output logic [3:0] key_code
);

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int IDLE_W = $clog2(SCAN_WINDOW + 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = (DEBOUNCE_CYCLES > 1) ? DEB_W'(DEBOUNCE_CYCLES - 2) : '0;
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(SCAN_WINDOW);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SCAN_WINDOW - 1);
   localparam bit                INSTANT   = (DEBOUNCE_CYCLES == 1);

   deb_state_e        state, state_n;
   logic [3:0]        cand, cand_n;
   logic [DEB_W-1:0]  deb_cnt, deb_cnt_n;
   logic [IDLE_W-1:0] idle_cnt;
   logic              released;
   logic              start;

   // Release is the cycle in which the idle count would reach the window; a hit always wins.
   assign released = !key_intro && (idle_cnt >= IDLE_LAST);
   assign start    = (state == ST_IDLE) ? key_intro : (key_intro && (key_value != cand));

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (key_intro) begin
         idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cand    <= '0;
         deb_cnt <= '0;
      end else begin
         state   <= state_n;
         cand    <= cand_n;
         deb_cnt <= deb_cnt_n;
      end
   end

`ifdef KEY_ENTRY_REPEAT_EN
   localparam int               REP_W    = $clog2(REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt, rep_cnt_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt_n;
      end
   end
`else
   if (REPEAT_CYCLES < 1) begin : g_repeat_cfg_unused
   end
`endif

   always_comb begin
      state_n   = state;
      cand_n    = cand;
      deb_cnt_n = deb_cnt;
      key_event = 1'b0;
      key_code  = cand;
`ifdef KEY_ENTRY_REPEAT_EN
      rep_cnt_n = '0;
`endif
      if (start) begin
         // A fresh or changed key restarts the debounce window.
         cand_n    = key_value;
         deb_cnt_n = '0;
         key_code  = key_value;
         if (INSTANT) begin
            state_n   = ST_HELD;
            key_event = 1'b1;
         end else begin
            state_n = ST_DEBOUNCE;
         end
      end else begin
         case (state)
            ST_DEBOUNCE: begin
               if (released) begin
                  state_n = ST_IDLE;
               end else if (deb_cnt == DEB_LAST) begin
                  state_n   = ST_HELD;
                  key_event = 1'b1;
               end else begin
                  deb_cnt_n = deb_cnt + 1'b1;
               end
            end
            ST_HELD: begin
               if (released) begin
                  state_n = ST_IDLE;
               end
`ifdef KEY_ENTRY_REPEAT_EN
               else if (rep_cnt == REP_LAST) begin
                  key_event = is_digit(cand) || (cand == KEY_BKSP);
               end else begin
                  rep_cnt_n = rep_cnt + 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/key_entry.sv
// Keypad entry: debounced keys build a 4-digit BCD operand; operator keys are
// handed to the core with an operand snapshot. Optional macro: KEY_ENTRY_REPEAT_EN.
module key_entry
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SCAN_WINDOW     = 8,
   parameter int REPEAT_CYCLES   = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  key_value,
   input  logic        key_intro,
   output logic [15:0] operand,
   output logic [2:0]  digit_count,
   output logic        op_valid,
   output logic [2:0]  op_code,
   output logic [15:0] op_operand,
   input  logic        op_ready,
   output logic        key_drop
);

   logic       key_event;
   logic [3:0] key_code;
   logic [3:0] op_idx;
   logic       xfer;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SCAN_WINDOW     (SCAN_WINDOW),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .key_value (key_value),
      .key_intro (key_intro),
      .key_event (key_event),
      .key_code  (key_code)
   );

   assign xfer   = op_valid && op_ready;
   assign op_idx = key_code - KEY_ADD;

   always_ff @(posedge clk) begin
      if (rst) begin
         operand     <= '0;
         digit_count <= '0;
         op_valid    <= 1'b0;
         op_code     <= '0;
         op_operand  <= '0;
         key_drop    <= 1'b0;
      end else begin
         key_drop <= 1'b0;
         if (xfer) begin
            op_valid <= 1'b0;
         end
         if (key_event) begin
            // A still-pending operator blocks every key, digits included.
            if (op_valid && !xfer) begin
               key_drop <= 1'b1;
            end else if (is_digit(key_code)) begin
               if (digit_count < 3'(NUM_DIGITS)) begin
                  operand     <= {operand[15-BCD_W:0], key_code};
                  digit_count <= digit_count + 1'b1;
               end else begin
                  key_drop <= 1'b1;
               end
            end else if (key_code == KEY_BKSP) begin
               if (digit_count != 3'd0) begin
                  operand     <= {{BCD_W{1'b0}}, operand[15:BCD_W]};
                  digit_count <= digit_count - 1'b1;
               end
            end else begin
               op_valid    <= 1'b1;
               op_code     <= op_idx[2:0];
               op_operand  <= operand;
               operand     <= '0;
               digit_count <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_key_entry.sv
// Randomized bench for key_entry against a timeline model of press events and
// a digit-queue model of operand entry and the operator handshake.
module tb_key_entry;

   localparam int D = 4;
   localparam int W = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  key_value;
   logic        key_intro;
   logic [15:0] operand;
   logic [2:0]  digit_count;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [15:0] op_operand;
   logic        op_ready;
   logic        key_drop;

   key_entry #(
      .DEBOUNCE_CYCLES (D),
      .SCAN_WINDOW     (W),
      .REPEAT_CYCLES   (64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_value   (key_value),
      .key_intro   (key_intro),
      .operand     (operand),
      .digit_count (digit_count),
      .op_valid    (op_valid),
      .op_code     (op_code),
      .op_operand  (op_operand),
      .op_ready    (op_ready),
      .key_drop    (key_drop)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // press timeline model
   bit m_active;
   bit m_fired;
   int m_cand;
   int m_start;
   int m_last;
   // entry model
   int digits[$];
   bit m_pv;
   int m_pcode;
   int m_pop;
   bit m_drop;

   bit rand_ready = 1'b0;
   bit drop_seen  = 1'b0;

   function automatic int pack_digits();
      int v = 0;
      foreach (digits[i]) v = (v << 4) | digits[i];
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit ev;
      bit xfer;
      bit busy;
      int k;
      if (rst) begin
         m_active = 0;
         m_fired  = 0;
         digits.delete();
         m_pv    = 0;
         m_pcode = 0;
         m_pop   = 0;
         m_drop  = 0;
         return;
      end
      ev = 0;
      if (key_intro) begin
         if (!m_active || key_value != m_cand) begin
            m_active = 1;
            m_cand   = key_value;
            m_start  = cyc;
            m_fired  = 0;
         end
         m_last = cyc;
      end else if (m_active && (cyc - m_last) >= W) begin
         m_active = 0;
      end
      if (m_active && !m_fired && cyc == m_start + D - 1) begin
         ev      = 1;
         m_fired = 1;
      end
      k      = m_cand;
      m_drop = 0;
      xfer   = m_pv && op_ready;
      busy   = m_pv && !xfer;
      if (xfer) m_pv = 0;
      if (ev) begin
         if (busy) m_drop = 1;
         else if (k < 10) begin
            if (digits.size() < 4) digits.push_back(k);
            else m_drop = 1;
         end else if (k == 15) begin
            if (digits.size() > 0) void'(digits.pop_back());
         end else begin
            m_pv    = 1;
            m_pcode = k - 10;
            m_pop   = pack_digits();
            digits.delete();
         end
      end
   endtask

   task automatic tick(input bit intro, input logic [3:0] val);
      if (rand_ready) op_ready = ($urandom_range(0, 2) != 0);
      key_intro = intro;
      key_value = intro ? val : 4'($urandom_range(0, 15));
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      chk("operand", operand, pack_digits());
      chk("digit_count", digit_count, digits.size());
      chk("op_valid", op_valid, m_pv);
      chk("op_code", op_code, m_pcode);
      chk("op_operand", op_operand, m_pop);
      chk("key_drop", key_drop, m_drop);
      if (key_drop) drop_seen = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 4'd0);
   endtask

   task automatic press(input logic [3:0] key, input int periods);
      for (int p = 0; p < periods; p++) begin
         tick(1'b1, key);
         idle(3);
      end
      idle(12);
   endtask

   task automatic press_rand();
      int r;
      int key;
      int hits;
      int gap;
      r = $urandom_range(0, 99);
      if (r < 70) key = $urandom_range(0, 9);
      else if (r < 85) key = 15;
      else key = $urandom_range(10, 14);
      if ($urandom_range(0, 3) == 0) tick(1'b1, 4'($urandom_range(0, 15)));
      hits = $urandom_range(1, 4);
      for (int h = 0; h < hits; h++) begin
         tick(1'b1, 4'(key));
         gap = $urandom_range(1, 10);
         idle(gap - 1);
      end
      if ($urandom_range(0, 40) == 0) begin
         rst = 1'b1;
         tick(1'b0, 4'd0);
         rst = 1'b0;
      end
      idle($urandom_range(0, 12));
   endtask

   initial begin
      rst       = 1'b1;
      op_ready  = 1'b1;
      key_intro = 1'b0;
      key_value = 4'd0;
      idle(2);
      chk("pin_reset_operand", operand, 0);
      chk("pin_reset_op_valid", op_valid, 0);
      chk("pin_reset_key_drop", key_drop, 0);
      rst = 1'b0;
      idle(3);

      // steady key 7 for 40 cycles
      press(4'd7, 10);
      chk("pin_k7_operand", operand, 16'h0007);
      chk("pin_k7_count", digit_count, 1);
      press(4'd14, 2);

      // alternating bounce straight into a stable hold of key 6
      for (int b = 0; b < 4; b++) begin
         tick(1'b1, 4'd3);
         tick(1'b1, 4'd5);
      end
      press(4'd6, 3);
      chk("pin_bounce_operand", operand, 16'h0006);
      chk("pin_bounce_count", digit_count, 1);
      press(4'd14, 2);

      // overflow on the fifth digit
      for (int d = 1; d <= 4; d++) press(4'(d), 2);
      drop_seen = 1'b0;
      press(4'd5, 2);
      chk("pin_overflow_operand", operand, 16'h1234);
      chk("pin_overflow_count", digit_count, 4);
      chk("pin_overflow_drop", drop_seen, 1);
      press(4'd14, 2);

      // operator stalled by op_ready
      press(4'd4, 2);
      press(4'd2, 2);
      op_ready = 1'b0;
      press(4'd10, 2);
      chk("pin_add_valid", op_valid, 1);
      chk("pin_add_code", op_code, 0);
      chk("pin_add_operand", op_operand, 16'h0042);
      chk("pin_add_entry", operand, 0);
      drop_seen = 1'b0;
      press(4'd9, 2);
      chk("pin_stall_drop", drop_seen, 1);
      chk("pin_stall_entry", operand, 0);
      idle(5);
      chk("pin_stall_operand", op_operand, 16'h0042);
      op_ready = 1'b1;
      tick(1'b0, 4'd0);
      chk("pin_xfer_valid", op_valid, 0);
      idle(2);

      // backspace
      drop_seen = 1'b0;
      press(4'd9, 2);
      press(4'd8, 2);
      chk("pin_bk_98", operand, 16'h0098);
      press(4'd15, 2);
      chk("pin_bk_09", operand, 16'h0009);
      press(4'd15, 2);
      press(4'd15, 2);
      chk("pin_bk_00", operand, 0);
      chk("pin_bk_count", digit_count, 0);
      chk("pin_bk_nodrop", drop_seen, 0);

      // reset mid-debounce with an operator pending
      press(4'd3, 2);
      op_ready = 1'b0;
      press(4'd11, 2);
      tick(1'b1, 4'd5);
      tick(1'b0, 4'd0);
      rst = 1'b1;
      tick(1'b0, 4'd0);
      rst = 1'b0;
      chk("pin_rst_valid", op_valid, 0);
      chk("pin_rst_code", op_code, 0);
      chk("pin_rst_op_operand", op_operand, 0);
      chk("pin_rst_operand", operand, 0);
      idle(20);
      chk("pin_rst_noevent", digit_count, 0);
      op_ready = 1'b1;

      // randomized traffic
      rand_ready = 1'b1;
      for (int n = 0; n < 150; n++) press_rand();
      rand_ready = 1'b0;
      op_ready   = 1'b1;
      idle(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
